core_mem_bridge: RTL and testbench

//  Memory-side responder for the pipeline core's fetch and load/store request ports.

---
 rtl/core_mem_bridge_pkg.sv | 34 +++
 rtl/core_mem_bridge_if.sv | 56 +++++
 rtl/core_mem_bridge_axi_wr_ch.sv | 40 ++++
 rtl/core_mem_bridge.sv | 174 +++++++++++++++++
 tb/tb_core_mem_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_bridge_pkg.sv
// core_mem_bridge_pkg
//   Shared widths, FSM state encodings and helpers for the core-to-AXI4-Lite
//   memory bridge.
//   Contents:
//     ADDR_W / DATA_W / STRB_W / INSTR_W : bus and instruction widths
//     bridge_state_e                     : bridge FSM state codes
//     pick_instr()                       : selects one instruction from a beat

package core_mem_bridge_pkg;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int STRB_W  = DATA_W / 8;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        BRIDGE_ST_IDLE   = 3'd0,
        BRIDGE_ST_LD_AR  = 3'd1,
        BRIDGE_ST_LD_R   = 3'd2,
        BRIDGE_ST_ST_AW_W = 3'd3,
        BRIDGE_ST_ST_B   = 3'd4,
        BRIDGE_ST_IF_AR  = 3'd5,
        BRIDGE_ST_IF_R   = 3'd6
    } bridge_state_e;

    // A beat carries two instructions; pc bit 2 selects the upper one.
    function automatic logic [INSTR_W-1:0] pick_instr(
        input logic [DATA_W-1:0] rdata,
        input logic              pc_bit2
    );
        return pc_bit2 ? rdata[DATA_W-1:INSTR_W] : rdata[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/core_mem_bridge_if.sv
// core_mem_bridge_if
//   AXI4-Lite bus between the bridge (master) and the SoC interconnect (slave).
//   Ports (signals):
//     m_araddr/m_arvalid/m_arready : read address channel
//     m_rdata/m_rvalid/m_rready    : read data channel
//     m_awaddr/m_awvalid/m_awready : write address channel
//     m_wdata/m_wstrb/m_wvalid/m_wready : write data channel
//     m_bvalid/m_bready            : write response channel
//   Response codes are not carried; the bridge treats every response as OK.

interface core_mem_bridge_if;
    import core_mem_bridge_pkg::*;

    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rready;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic              m_bvalid;
    logic              m_bready;

    modport master (
        output m_araddr, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rvalid,
        output m_rready,
        output m_awaddr, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wvalid,
        input  m_wready,
        input  m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_araddr, m_arvalid,
        output m_arready,
        output m_rdata, m_rvalid,
        input  m_rready,
        input  m_awaddr, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wvalid,
        output m_wready,
        output m_bvalid,
        input  m_bready
    );

endinterface

// File: rtl/core_mem_bridge_axi_wr_ch.sv
// core_mem_bridge_axi_wr_ch
//   Owns AWVALID and WVALID for one store. Both rise together on start and
//   each falls on its own handshake, so the interconnect may accept AW and W
//   in either order or in the same cycle.
//   Ports:
//     clk, rst_n        : clock, async active-low reset
//     start_i           : store leaving IDLE (valids rise next edge)
//     awready_i, wready_i : channel readies from the interconnect
//     awvalid_o, wvalid_o : registered channel valids
//     done_o            : last outstanding handshake of the pair is happening now

module core_mem_bridge_axi_wr_ch (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic done_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
        end else if (start_i) begin
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
        end else begin
            if (awready_i) awvalid_o <= 1'b0;
            if (wready_i)  wvalid_o  <= 1'b0;
        end
    end

    assign done_o = (awvalid_o | wvalid_o)
                  & (~awvalid_o | awready_i)
                  & (~wvalid_o  | wready_i);

endmodule

// File: rtl/core_mem_bridge.sv
// core_mem_bridge
//   Memory-side responder for the core's fetch and load/store ports. Serializes
//   fetches, loads and stores onto one AXI4-Lite master, one transaction at a
//   time, and stalls the core until each request has completed.
//   Ports:
//     clk, rst_n                      : clock, async active-low reset
//     instr_rd_en_i, pc_i             : fetch request (level) and address
//     mem_rd_en_i, addr_mem_rd_i      : load request (level) and address
//     mem_wr_en_i, addr_mem_wr_i,
//     data_mem_wr_i, strb_mem_wr_i    : store request, address, lane data, strobes
//     instr_o, addr_instr_o           : fetched instruction and its pc
//     data_mem_o                      : raw load beat
//     stall_if_o, stall_mem_o         : request not yet complete
//     m_axi                           : AXI4-Lite master bus
//
//   state         | meaning
//   --------------+--------------------------------------------------
//   IDLE          | no transaction; picks store > load > fetch
//   LD_AR         | load address offered on AR
//   LD_R          | waiting for load beat
//   ST_AW_W       | store address and data offered on AW/W
//   ST_B          | waiting for write response
//   IF_AR         | fetch address offered on AR
//   IF_R          | waiting for fetch beat

module core_mem_bridge
    import core_mem_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_rd_en_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                mem_rd_en_i,
    input  logic [ADDR_W-1:0]   addr_mem_rd_i,
    input  logic                mem_wr_en_i,
    input  logic [ADDR_W-1:0]   addr_mem_wr_i,
    input  logic [DATA_W-1:0]   data_mem_wr_i,
    input  logic [STRB_W-1:0]   strb_mem_wr_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   addr_instr_o,
    output logic [DATA_W-1:0]   data_mem_o,
    output logic                stall_if_o,
    output logic                stall_mem_o,
    core_mem_bridge_if.master   m_axi
);

    bridge_state_e     state;
    logic [ADDR_W-1:0] req_pc;
    logic              if_done;
    logic              mem_done;
    logic              advance;
    logic              st_start;
    logic              wr_done;

    // Done flags stop a completed request from being re-issued while the
    // core is still held by the other port.
    assign stall_if_o  = instr_rd_en_i & ~if_done;
    assign stall_mem_o = (mem_rd_en_i | mem_wr_en_i) & ~mem_done;
    assign advance     = ~stall_if_o & ~stall_mem_o;

    assign st_start = (state == BRIDGE_ST_IDLE) & mem_wr_en_i & ~mem_done;

    core_mem_bridge_axi_wr_ch u_wr_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (st_start),
        .awready_i (m_axi.m_awready),
        .wready_i  (m_axi.m_wready),
        .awvalid_o (m_axi.m_awvalid),
        .wvalid_o  (m_axi.m_wvalid),
        .done_o    (wr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BRIDGE_ST_IDLE;
            req_pc          <= '0;
            if_done         <= 1'b0;
            mem_done        <= 1'b0;
            instr_o         <= '0;
            addr_instr_o    <= '0;
            data_mem_o      <= '0;
            m_axi.m_araddr  <= '0;
            m_axi.m_arvalid <= 1'b0;
            m_axi.m_rready  <= 1'b0;
            m_axi.m_awaddr  <= '0;
            m_axi.m_wdata   <= '0;
            m_axi.m_wstrb   <= '0;
            m_axi.m_bready  <= 1'b0;
        end else begin
            // Completion below overrides this clear, so a result that lands
            // during an advance (e.g. after a flush) keeps its done flag.
            if (advance) begin
                if_done  <= 1'b0;
                mem_done <= 1'b0;
            end

            case (state)
                BRIDGE_ST_IDLE: begin
                    if (mem_wr_en_i && !mem_done) begin
                        m_axi.m_awaddr <= addr_mem_wr_i;
                        m_axi.m_wdata  <= data_mem_wr_i;
                        m_axi.m_wstrb  <= strb_mem_wr_i;
                        state          <= BRIDGE_ST_ST_AW_W;
                    end else if (mem_rd_en_i && !mem_done) begin
                        m_axi.m_araddr  <= addr_mem_rd_i;
                        m_axi.m_arvalid <= 1'b1;
                        state           <= BRIDGE_ST_LD_AR;
                    end else if (instr_rd_en_i && !if_done) begin
                        m_axi.m_araddr  <= pc_i;
                        m_axi.m_arvalid <= 1'b1;
                        req_pc          <= pc_i;
                        state           <= BRIDGE_ST_IF_AR;
                    end
                end

                BRIDGE_ST_LD_AR: begin
                    if (m_axi.m_arready) begin
                        m_axi.m_arvalid <= 1'b0;
                        m_axi.m_rready  <= 1'b1;
                        state           <= BRIDGE_ST_LD_R;
                    end
                end

                BRIDGE_ST_LD_R: begin
                    if (m_axi.m_rvalid) begin
                        data_mem_o     <= m_axi.m_rdata;
                        m_axi.m_rready <= 1'b0;
                        mem_done       <= 1'b1;
                        state          <= BRIDGE_ST_IDLE;
                    end
                end

                BRIDGE_ST_ST_AW_W: begin
                    if (wr_done) begin
                        m_axi.m_bready <= 1'b1;
                        state          <= BRIDGE_ST_ST_B;
                    end
                end

                BRIDGE_ST_ST_B: begin
                    if (m_axi.m_bvalid) begin
                        m_axi.m_bready <= 1'b0;
                        mem_done       <= 1'b1;
                        state          <= BRIDGE_ST_IDLE;
                    end
                end

                BRIDGE_ST_IF_AR: begin
                    if (m_axi.m_arready) begin
                        m_axi.m_arvalid <= 1'b0;
                        m_axi.m_rready  <= 1'b1;
                        state           <= BRIDGE_ST_IF_R;
                    end
                end

                BRIDGE_ST_IF_R: begin
                    if (m_axi.m_rvalid) begin
                        instr_o        <= pick_instr(m_axi.m_rdata, req_pc[2]);
                        addr_instr_o   <= req_pc;
                        m_axi.m_rready <= 1'b0;
                        if_done        <= 1'b1;
                        state          <= BRIDGE_ST_IDLE;
                    end
                end

                default: begin
                    state <= BRIDGE_ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_bridge.sv
`timescale 1ns/1ps
module tb_core_mem_bridge;
    import core_mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_rd_en, mem_rd_en, mem_wr_en;
    logic [63:0] pc, addr_rd, addr_wr, data_wr;
    logic [7:0]  strb_wr;
    logic [31:0] instr_o;
    logic [63:0] addr_instr_o, data_mem_o;
    logic        stall_if_o, stall_mem_o;

    core_mem_bridge_if bus ();

    core_mem_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_rd_en_i (instr_rd_en),
        .pc_i          (pc),
        .mem_rd_en_i   (mem_rd_en),
        .addr_mem_rd_i (addr_rd),
        .mem_wr_en_i   (mem_wr_en),
        .addr_mem_wr_i (addr_wr),
        .data_mem_wr_i (data_wr),
        .strb_mem_wr_i (strb_wr),
        .instr_o       (instr_o),
        .addr_instr_o  (addr_instr_o),
        .data_mem_o    (data_mem_o),
        .stall_if_o    (stall_if_o),
        .stall_mem_o   (stall_mem_o),
        .m_axi         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
    } if_exp_t;

    logic [63:0] exp_ar[$];
    logic [63:0] exp_aw[$];
    logic [71:0] exp_w[$];
    logic [63:0] exp_ld[$];
    if_exp_t     exp_if[$];

    // Slave memory contents: the first beat holds two known instructions.
    function automatic logic [63:0] beat(input logic [63:0] a);
        if (a[63:3] == 61'h10000000) return 64'h00000013_00100093;
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_if(output int n);
        n = 0;
        while (stall_if_o === 1'b1 && n < 100) begin step(); n++; end
    endtask

    task automatic wait_mem(output int n);
        n = 0;
        while (stall_mem_o === 1'b1 && n < 100) begin step(); n++; end
    endtask

    // AXI4-Lite slave + monitor. Runs at negedge: readies chosen here are the
    // ones sampled at the next posedge, so handshakes are known in advance.
    initial begin : slave
        int ar_w, r_w, aw_w, w_w, b_w;
        logic r_pend, aw_got, w_got, b_pend;
        logic ar_hold, aw_hold, w_hold;
        logic [63:0] r_beat, ar_hold_a, aw_hold_a;
        logic [71:0] w_hold_v;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0;
        r_beat = '0; ar_hold_a = '0; aw_hold_a = '0; w_hold_v = '0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
                bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                ar_hold = 0; aw_hold = 0; w_hold = 0;
                ar_w = 0; aw_w = 0; w_w = 0;
            end else begin
                if (ar_hold) chk("ar_stable", {bus.m_arvalid, bus.m_araddr}, {1'b1, ar_hold_a});
                if (aw_hold) chk("aw_stable", {bus.m_awvalid, bus.m_awaddr}, {1'b1, aw_hold_a});
                if (w_hold)  chk("w_stable", {bus.m_wvalid, bus.m_wstrb, bus.m_wdata}, {1'b1, w_hold_v});
                ar_hold = 0; aw_hold = 0; w_hold = 0;

                if (r_pend) begin
                    bus.m_rvalid = (r_w >= r_lat);
                    bus.m_rdata  = bus.m_rvalid ? r_beat : 64'h0;
                    r_w++;
                end else begin
                    bus.m_rvalid = 0;
                    bus.m_rdata  = '0;
                end
                if (bus.m_rvalid && bus.m_rready) begin r_pend = 0; r_hs++; end

                if (bus.m_arvalid) begin bus.m_arready = (ar_w >= ar_lat); ar_w++; end
                else begin bus.m_arready = 0; ar_w = 0; end
                if (bus.m_arvalid && bus.m_arready) begin
                    ar_hs++; ar_w = 0;
                    chk("ar_expected", exp_ar.size() != 0, 1);
                    if (exp_ar.size() != 0) chk("ar_addr", bus.m_araddr, exp_ar.pop_front());
                    r_pend = 1; r_w = 0; r_beat = beat(bus.m_araddr);
                end else if (bus.m_arvalid) begin
                    ar_hold = 1; ar_hold_a = bus.m_araddr;
                end

                if (bus.m_bready) chk("bready_after_aw_w", aw_got & w_got, 1);
                if (b_pend) begin bus.m_bvalid = (b_w >= b_lat); b_w++; end
                else bus.m_bvalid = 0;
                if (bus.m_bvalid && bus.m_bready) begin
                    b_hs++; b_pend = 0; aw_got = 0; w_got = 0;
                end

                if (bus.m_awvalid) begin bus.m_awready = (aw_w >= aw_lat); aw_w++; end
                else begin bus.m_awready = 0; aw_w = 0; end
                if (bus.m_awvalid && bus.m_awready) begin
                    aw_hs++; aw_w = 0; aw_got = 1;
                    chk("aw_expected", exp_aw.size() != 0, 1);
                    if (exp_aw.size() != 0) chk("aw_addr", bus.m_awaddr, exp_aw.pop_front());
                end else if (bus.m_awvalid) begin
                    aw_hold = 1; aw_hold_a = bus.m_awaddr;
                end

                if (bus.m_wvalid) begin bus.m_wready = (w_w >= w_lat); w_w++; end
                else begin bus.m_wready = 0; w_w = 0; end
                if (bus.m_wvalid && bus.m_wready) begin
                    w_hs++; w_w = 0; w_got = 1;
                    chk("w_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) chk("w_data_strb", {bus.m_wstrb, bus.m_wdata}, exp_w.pop_front());
                end else if (bus.m_wvalid) begin
                    w_hold = 1; w_hold_v = {bus.m_wstrb, bus.m_wdata};
                end

                if (aw_got && w_got && !b_pend) begin b_pend = 1; b_w = 0; end
            end
        end
    end

    initial begin : watchdog
        #400000;
        n_err++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, base_ar, base_aw, base_w, base_b, ar_at_ld;
        if_exp_t e;
        rst_n = 0; instr_rd_en = 1; mem_rd_en = 0; mem_wr_en = 0;
        pc = '0; addr_rd = '0; addr_wr = '0; data_wr = '0; strb_wr = '0;

        // Reset values; stall follows the request combinationally.
        #12;
        chk("rst_arvalid", bus.m_arvalid, 0);
        chk("rst_rready", bus.m_rready, 0);
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_bready", bus.m_bready, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_addr_instr", addr_instr_o, 0);
        chk("rst_data_mem", data_mem_o, 0);
        chk("rst_stall_if", stall_if_o, 1);
        chk("rst_stall_mem", stall_mem_o, 0);
        instr_rd_en = 0;
        @(negedge clk); #2;
        rst_n = 1;

        // Fetch with immediate slave.
        step();
        instr_rd_en = 1; pc = 64'h8000_0000;
        exp_ar.push_back(pc);
        e.addr = pc; e.instr = beat(pc)[31:0]; exp_if.push_back(e);
        #1;
        wait_if(n);
        chk("if1_stall_cycles", n, 3);
        e = exp_if.pop_front();
        chk("if1_instr", instr_o, e.instr);
        chk("if1_instr_const", instr_o, 32'h0010_0093);
        chk("if1_addr", addr_instr_o, e.addr);

        // Next fetch presented on the advance; R delayed 5 cycles.
        pc = 64'h8000_0004; r_lat = 5;
        exp_ar.push_back(pc);
        e.addr = pc; e.instr = 32'h0000_0013; exp_if.push_back(e);
        step();
        chk("if1_low_one_cycle", stall_if_o, 1);
        wait_if(n);
        chk("if2_stall_cycles", n, 3 + 5);
        e = exp_if.pop_front();
        chk("if2_instr", instr_o, e.instr);
        chk("if2_addr", addr_instr_o, e.addr);
        chk("if_ar_count", ar_hs, 2);
        instr_rd_en = 0; r_lat = 0;
        step();

        // Store with W accepted two cycles before AW.
        base_aw = aw_hs; base_w = w_hs; base_b = b_hs;
        w_lat = 0; aw_lat = 2; b_lat = 1;
        mem_wr_en = 1; addr_wr = 64'h1000; data_wr = 64'h1122_3344_5566_7788; strb_wr = 8'h0F;
        exp_aw.push_back(addr_wr); exp_w.push_back({strb_wr, data_wr});
        #1;
        wait_mem(n);
        chk("st1_stall_cycles", n, 6);
        chk("st1_aw_count", aw_hs - base_aw, 1);
        chk("st1_w_count", w_hs - base_w, 1);
        chk("st1_b_count", b_hs - base_b, 1);
        mem_wr_en = 0; aw_lat = 0; b_lat = 0;
        step();

        // Load and fetch together: load goes first.
        base_ar = ar_hs; ar_at_ld = -1;
        mem_rd_en = 1; addr_rd = 64'h2000; instr_rd_en = 1; pc = 64'h8000_0008;
        exp_ar.push_back(addr_rd); exp_ar.push_back(pc);
        exp_ld.push_back(beat(addr_rd));
        e.addr = pc; e.instr = beat(pc)[31:0]; exp_if.push_back(e);
        #1;
        n = 0;
        while ((stall_if_o === 1'b1 || stall_mem_o === 1'b1) && n < 100) begin
            if (stall_mem_o === 1'b0 && ar_at_ld < 0) ar_at_ld = ar_hs - base_ar;
            step(); n++;
        end
        chk("ldif_cycles", n, 6);
        chk("ldif_ar_when_load_done", ar_at_ld, 1);
        chk("ldif_ar_total", ar_hs - base_ar, 2);
        chk("ldif_load_data", data_mem_o, exp_ld.pop_front());
        e = exp_if.pop_front();
        chk("ldif_instr", instr_o, e.instr);
        chk("ldif_addr", addr_instr_o, e.addr);
        mem_rd_en = 0; instr_rd_en = 0;
        step();

        // Store completes while fetch still stalls: no repeat until advance.
        base_aw = aw_hs; base_w = w_hs;
        r_lat = 8;
        instr_rd_en = 1; pc = 64'h8000_000C;
        mem_wr_en = 1; addr_wr = 64'h3000; data_wr = 64'hCAFE_F00D_0BAD_BEEF; strb_wr = 8'hFF;
        exp_aw.push_back(addr_wr); exp_w.push_back({strb_wr, data_wr});
        exp_ar.push_back(pc);
        e.addr = pc; e.instr = beat(pc)[63:32]; exp_if.push_back(e);
        #1;
        n = 0;
        while ((stall_if_o === 1'b1 || stall_mem_o === 1'b1) && n < 100) begin step(); n++; end
        chk("stif_aw_once", aw_hs - base_aw, 1);
        chk("stif_w_once", w_hs - base_w, 1);
        e = exp_if.pop_front();
        chk("stif_instr_hi", instr_o, e.instr);
        chk("stif_addr", addr_instr_o, e.addr);
        instr_rd_en = 0; r_lat = 0;
        addr_wr = 64'h3008; data_wr = 64'h0102_0304_0506_0708; strb_wr = 8'hF0;
        exp_aw.push_back(addr_wr); exp_w.push_back({strb_wr, data_wr});
        step();
        wait_mem(n);
        chk("st2_stall_cycles", n, 3);
        chk("st2_aw_total", aw_hs - base_aw, 2);
        mem_wr_en = 0;
        step(); step(); step();
        chk("st2_no_repeat", aw_hs - base_aw, 2);

        // Reset while waiting for the load beat.
        ar_lat = 0; r_lat = 20;
        mem_rd_en = 1; addr_rd = 64'h4000;
        exp_ar.push_back(addr_rd);
        step(); step();
        chk("ldr_in_r_phase", bus.m_rready, 1);
        #1 rst_n = 0;
        #1;
        chk("rst2_arvalid", bus.m_arvalid, 0);
        chk("rst2_rready", bus.m_rready, 0);
        chk("rst2_awvalid", bus.m_awvalid, 0);
        chk("rst2_wvalid", bus.m_wvalid, 0);
        chk("rst2_bready", bus.m_bready, 0);
        chk("rst2_data_mem", data_mem_o, 0);
        chk("rst2_instr", instr_o, 0);
        chk("rst2_addr_instr", addr_instr_o, 0);
        chk("rst2_stall_mem", stall_mem_o, 1);
        mem_rd_en = 0; r_lat = 0;
        step();
        rst_n = 1;
        step();

        // Bridge is usable again straight out of reset.
        mem_rd_en = 1; addr_rd = 64'h5008;
        exp_ar.push_back(addr_rd); exp_ld.push_back(beat(addr_rd));
        #1;
        wait_mem(n);
        chk("ld3_stall_cycles", n, 3);
        chk("ld3_data", data_mem_o, exp_ld.pop_front());
        mem_rd_en = 0;
        step();

        chk("sb_ar_empty", exp_ar.size(), 0);
        chk("sb_aw_empty", exp_aw.size(), 0);
        chk("sb_w_empty", exp_w.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
